// File: rtl/alu_multicycle_if.sv
// Start/done handshake bundle for alu_multicycle.
// The overflow signal exists only when ALU_MC_OVF_EN is defined.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [2:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;
  logic             cout;
  logic             zero;
`ifdef ALU_MC_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, dataA, dataB, Signal,
`ifdef ALU_MC_OVF_EN
    input  overflow,
`endif
    input  busy, done, dataOut, cout, zero
  );

  modport slave (
    input  start, dataA, dataB, Signal,
`ifdef ALU_MC_OVF_EN
    output overflow,
`endif
    output busy, done, dataOut, cout, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: AND/OR/ADD/SUB/SLT, SLICE bits per clock, LSB chunk first.
// Optional macro ALU_MC_OVF_EN adds the signed-overflow output.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_multicycle_if.slave bus
);

  localparam int NCHUNK = WIDTH / SLICE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] res_reg;
  logic             slt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             cout_reg;
  logic             zero_reg;
`ifdef ALU_MC_OVF_EN
  logic             ovf_reg;
`endif

  logic             is_add;
  logic             is_slt;
  logic             is_logic;
  logic [SLICE-1:0] a_arr [NCHUNK];
  logic [SLICE-1:0] b_arr [NCHUNK];
  logic [SLICE-1:0] a_ch;
  logic [SLICE-1:0] b_raw;
  logic [SLICE-1:0] b_ch;
  logic [SLICE:0]   sum_ch;
  logic [SLICE-1:0] chunk_res;
  logic             c_out;
  logic             c_msb_in;
  logic             ovf;
  logic             slt_bit;
  logic             last;
  logic [WIDTH-1:0] res_merged;

  assign is_add   = (op_reg == 3'b010);
  assign is_slt   = (op_reg == 3'b111);
  assign is_logic = (op_reg[2:1] == 2'b00);

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_arr[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_arr[gi] = b_reg[gi*SLICE +: SLICE];
      // Full result as it will look once the current chunk is written.
      assign res_merged[gi*SLICE +: SLICE] =
        (cnt_reg == CW'(gi)) ? chunk_res : res_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_ch   = a_arr[cnt_reg];
  assign b_raw  = b_arr[cnt_reg];
  assign b_ch   = is_add ? b_raw : ~b_raw;
  assign sum_ch = {1'b0, a_ch} + {1'b0, b_ch} + {{SLICE{1'b0}}, carry_reg};
  assign c_out  = sum_ch[SLICE];
  // Carry into the chunk MSB recovered from its sum bit; only meaningful on the top chunk.
  assign c_msb_in = a_ch[SLICE-1] ^ b_ch[SLICE-1] ^ sum_ch[SLICE-1];
  assign ovf      = c_msb_in ^ c_out;
  assign slt_bit  = sum_ch[SLICE-1] ^ ovf;
  assign last     = (cnt_reg == CW'(NCHUNK - 1));

  always_comb begin
    chunk_res = sum_ch[SLICE-1:0];
    if (op_reg == 3'b000) begin
      chunk_res = a_ch & b_raw;
    end else if (op_reg == 3'b001) begin
      chunk_res = a_ch | b_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      res_reg   <= '0;
      slt_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dout_reg  <= '0;
      cout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
`ifdef ALU_MC_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg     <= bus.dataA;
            b_reg     <= bus.dataB;
            op_reg    <= bus.Signal;
            cnt_reg   <= '0;
            carry_reg <= (bus.Signal != 3'b010);
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          res_reg   <= res_merged;
          carry_reg <= c_out;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last) begin
            if (is_slt) begin
              slt_reg   <= slt_bit;
              state_reg <= SLT_FIX;
            end else begin
              dout_reg  <= res_merged;
              zero_reg  <= (res_merged == '0);
              cout_reg  <= is_logic ? 1'b0 : c_out;
`ifdef ALU_MC_OVF_EN
              ovf_reg   <= is_logic ? 1'b0 : ovf;
`endif
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        SLT_FIX: begin
          // carry_reg still holds the subtraction carry out of the MSB.
          dout_reg  <= {{(WIDTH-1){1'b0}}, slt_reg};
          zero_reg  <= ~slt_reg;
          cout_reg  <= carry_reg;
`ifdef ALU_MC_OVF_EN
          ovf_reg   <= 1'b0;
`endif
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.dataOut = dout_reg;
  assign bus.cout    = cout_reg;
  assign bus.zero    = zero_reg;
`ifdef ALU_MC_OVF_EN
  assign bus.overflow = ovf_reg;
`endif

endmodule
